aku_alu: RTL and testbench
==========================

// Module: aku_alu
// PURPOSE
//  8-bit ALU with an accumulator register; the ALU's A operand is the accumulator output.
//  Each enabled clock edge writes op(acc, b) back into the accumulator.
//  Execution datapath of the microprocessor: the control unit drives op/ce and the data bus drives b.
// PARAMETERS
//  none (fixed 8-bit data, 3-bit opcode)
// PORTS
//  clk     in   1  system clock; the accumulator updates on the rising edge
//  rst     in   1  asynchronous, active-high reset; clears the accumulator
//  ce      in   1  accumulator write enable
//  op      in   3  ALU operation code
//  b       in   8  B operand (data bus / immediate)
//  result  out  8  accumulator contents (also the ALU A operand)
//  cy      out  1  carry/borrow flag, combinational from the ALU
// BEHAVIOUR
//  - Reset: rst=1 forces result=8'h00 immediately, independent of clk, and holds it while asserted.
//    No other state exists.
//  - Register: on posedge clk with rst=0 and ce=1, acc <= alu_out. With ce=0, acc holds.
//  - Latency: one cycle from an op/b/ce setup to the new result. The ALU is purely combinational.
//  - cy is not registered. It always reflects the current acc, op and b.
//    It may change whenever those inputs change.
//  - Opcodes (a = acc):
//    0 ADD   out=a+b           cy = carry out of bit 7
//    1 SUB   out=a-b (mod 256) cy = borrow (1 when a<b)
//    2 AND   out=a&b           cy = 0
//    3 OR    out=a|b           cy = 0
//    4 XOR   out=a^b           cy = 0
//    5 NOT   out=~a            cy = 0
//    6 LDB   out=b (load)      cy = 0
//    7 SHL   out={a[6:0],1'b0} cy = a[7]
//  - Arithmetic uses a 9-bit unsigned internal sum; out = bits[7:0].
//    Wrap-around is silent, with no overflow output.
//  - ce=1 with any opcode is always legal. There are no illegal opcodes and no X on outputs after reset.
//  - Deasserting rst takes effect on the next posedge only (no glitch write on release).
// STRUCTURE
//  - Shared package holds the opcode localparams (OP_ADD..OP_SHL) and the data width constant (8).
//  - Leaf module alu: combinational; ports a, b, op, out, cy.
//  - Leaf module aku: register; ports clk, rst, ce, data_in, data_out.
//  - aku_alu instantiates both and feeds aku.data_out back as alu.a.
// TESTING
//  1 rst=1 with op=ADD, b=0 -> result=0x00, cy=0 without any clock edge. Release rst; result stays 0.
//  2 op=6, b=10, ce=1, one edge -> result=10, cy=0.
//    Then op=0, b=250: pre-edge cy=1; post-edge result=4.
//  3 acc=4, op=1, b=5, ce=1 -> cy=1 before the edge; result=0xFF after the edge.
//    Then b=0x0F: result=0xF0, cy=0.
//  4 Logic/shift: acc=0x81, op=7 -> cy=1, result=0x02.
//    Then acc=0xF0 with AND/OR/XOR b=0x3C -> 0x30/0xFC/0xCC; NOT of 0x81 -> 0x7E.
//  5 ce=0 for 5 cycles while cycling op/b -> result constant; cy still tracks the inputs.
//  6 Async reset mid-operation: acc=0x55, ce=1, assert rst between edges -> result=0 before the next edge.
//    Remains 0 across edges while rst=1.

Source files
------------

// File: rtl/aku_alu_pkg.sv
// Shared constants for the accumulator ALU: data width and opcode encodings.
package aku_alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_LDB = 3'd6;
    localparam logic [OP_W-1:0] OP_SHL = 3'd7;

endpackage

// File: rtl/aku.sv
// Accumulator register with write enable and asynchronous active-high clear.
module aku
    import aku_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= '0;
        else if (ce)
            data_out <= data_in;
    end

endmodule

// File: rtl/alu.sv
// Combinational 8-bit ALU; the A operand is the accumulator, cy carries
// the carry/borrow of arithmetic ops or the bit shifted out by SHL.
module alu
    import aku_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] out,
    output logic              cy
);

    logic [DATA_W:0] sum9;

    always_comb begin
        sum9 = '0;
        out  = '0;
        cy   = 1'b0;
        case (op)
            OP_ADD: begin
                sum9 = {1'b0, a} + {1'b0, b};
                out  = sum9[DATA_W-1:0];
                cy   = sum9[DATA_W];
            end
            // The 9-bit difference wraps, so bit 8 is set exactly when a < b.
            OP_SUB: begin
                sum9 = {1'b0, a} - {1'b0, b};
                out  = sum9[DATA_W-1:0];
                cy   = sum9[DATA_W];
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_LDB: out = b;
            OP_SHL: begin
                out = {a[DATA_W-2:0], 1'b0};
                cy  = a[DATA_W-1];
            end
            default: begin
                out = '0;
                cy  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/aku_alu.sv
// Execution datapath: accumulator register wrapped around a combinational ALU,
// with the accumulator output fed back as the ALU A operand.
module aku_alu
    import aku_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              cy
);

    logic [DATA_W-1:0] alu_out;

    alu u_alu (
        .a   (result),
        .b   (b),
        .op  (op),
        .out (alu_out),
        .cy  (cy)
    );

    aku u_aku (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .data_in  (alu_out),
        .data_out (result)
    );

endmodule

// File: tb/tb_aku_alu.sv
// Directed-vector bench for aku_alu with hand-computed expected values.
module tb_aku_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b0;
    logic [2:0] op  = 3'd0;
    logic [7:0] b   = 8'h00;
    logic [7:0] result;
    logic       cy;

    int n_vec = 0;
    int n_err = 0;

    aku_alu dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .op     (op),
        .b      (b),
        .result (result),
        .cy     (cy)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        ce = 1'b1; op = 3'd6; b = v;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: async reset without a clock edge, then release
        #1 rst = 1'b1;
        #1;
        chk8("rst_result", result, 8'h00);
        chk1("rst_cy", cy, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk8("release_result", result, 8'h00);

        // 2: load then add with carry
        ce = 1'b1; op = 3'd6; b = 8'd10;
        #1 chk1("ldb_cy", cy, 1'b0);
        tick();
        chk8("ldb_result", result, 8'd10);
        op = 3'd0; b = 8'd250;
        #1 chk1("add_cy_pre", cy, 1'b1);
        tick();
        chk8("add_result", result, 8'd4);
        chk1("add_cy_post", cy, 1'b0);

        // 3: subtract with borrow, then without
        op = 3'd1; b = 8'd5;
        #1 chk1("sub_borrow", cy, 1'b1);
        tick();
        chk8("sub_wrap", result, 8'hFF);
        b = 8'h0F;
        #1 chk1("sub_noborrow", cy, 1'b0);
        tick();
        chk8("sub_result", result, 8'hF0);

        // 4: shift and logic ops
        load(8'h81);
        op = 3'd7;
        #1 chk1("shl_cy", cy, 1'b1);
        tick();
        chk8("shl_result", result, 8'h02);
        load(8'hF0);
        op = 3'd2; b = 8'h3C;
        #1 chk1("and_cy", cy, 1'b0);
        tick();
        chk8("and_result", result, 8'h30);
        load(8'hF0);
        op = 3'd3; b = 8'h3C; tick();
        chk8("or_result", result, 8'hFC);
        load(8'hF0);
        op = 3'd4; b = 8'h3C; tick();
        chk8("xor_result", result, 8'hCC);
        load(8'h81);
        op = 3'd5; tick();
        chk8("not_result", result, 8'h7E);

        // 5: hold with ce=0 while cy tracks inputs (acc = 0x7E)
        ce = 1'b0;
        op = 3'd0; b = 8'h90;
        #1 chk1("hold_cy_add", cy, 1'b1);
        tick(); chk8("hold_r1", result, 8'h7E);
        op = 3'd1; b = 8'h7F;
        #1 chk1("hold_cy_sub1", cy, 1'b1);
        tick(); chk8("hold_r2", result, 8'h7E);
        op = 3'd1; b = 8'h10;
        #1 chk1("hold_cy_sub0", cy, 1'b0);
        tick(); chk8("hold_r3", result, 8'h7E);
        op = 3'd7; b = 8'hAA;
        #1 chk1("hold_cy_shl", cy, 1'b0);
        tick(); chk8("hold_r4", result, 8'h7E);
        op = 3'd0; b = 8'h81;
        #1 chk1("hold_cy_add0", cy, 1'b0);
        tick(); chk8("hold_r5", result, 8'h7E);

        // 6: async reset mid-operation
        load(8'h55);
        chk8("pre_rst_result", result, 8'h55);
        op = 3'd0; b = 8'h01;
        #2 rst = 1'b1;
        #1 chk8("mid_rst_result", result, 8'h00);
        tick(); chk8("rst_hold1", result, 8'h00);
        tick(); chk8("rst_hold2", result, 8'h00);
        chk1("rst_hold_cy", cy, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1 chk8("release_no_glitch", result, 8'h00);
        tick();
        chk8("post_rst_add", result, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
